// File: rtl/input_port_vc_buf.sv
// Router input port: one FIFO per virtual channel holding flit + look-ahead route,
// first-word-fall-through heads, one registered credit per pop, sticky protocol error.
module input_port_vc_buf #(
    parameter int VC_NUM   = 4,
    parameter int VC_DEPTH = 4,
    parameter int FLIT_W   = 64,
    parameter int ROUTE_W  = 3,
    localparam int VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int CNT_W    = $clog2(VC_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_flit_v_i,
    input  logic [FLIT_W-1:0]           rx_flit_i,
    input  logic [VC_IDX_W-1:0]         rx_flit_vc_id_i,
    input  logic [ROUTE_W-1:0]          rx_flit_look_ahead_routing_i,
    output logic                        rx_lcrd_v_o,
    output logic [VC_IDX_W-1:0]         rx_lcrd_id_o,
    output logic [VC_NUM-1:0]           vc_head_vld_o,
    output logic [VC_NUM*FLIT_W-1:0]    vc_head_flit_o,
    output logic [VC_NUM*ROUTE_W-1:0]   vc_head_route_o,
    input  logic [VC_NUM-1:0]           vc_pop_i,
    output logic [VC_NUM*CNT_W-1:0]     vc_occ_o,
    output logic                        err_o
);

    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam logic [VC_IDX_W:0] VC_NUM_W = VC_NUM[VC_IDX_W:0];

    logic [FLIT_W-1:0]  flit_mem  [VC_NUM][VC_DEPTH];
    logic [ROUTE_W-1:0] route_mem [VC_NUM][VC_DEPTH];
    logic [PTR_W-1:0]   wptr [VC_NUM];
    logic [PTR_W-1:0]   rptr [VC_NUM];
    logic [CNT_W-1:0]   occ  [VC_NUM];

    logic [VC_NUM-1:0]   wr_en;
    logic [VC_NUM-1:0]   pop_en;
    logic                id_ok;
    logic                pop_onehot;
    logic                err_set;
    logic [VC_IDX_W-1:0] wr_vc;
    logic [VC_IDX_W-1:0] pop_idx;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        id_ok      = (VC_NUM == 1) || ({1'b0, rx_flit_vc_id_i} < VC_NUM_W);
        wr_vc      = (VC_NUM == 1) ? '0 : rx_flit_vc_id_i;
        pop_onehot = $onehot(vc_pop_i);
        wr_en      = '0;
        pop_en     = '0;
        pop_idx    = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            pop_en[v] = vc_pop_i[v] && pop_onehot && (occ[v] != '0);
            if (pop_en[v])
                pop_idx = VC_IDX_W'(v);
        end
        // A full VC still accepts a write when it is popped in the same cycle.
        for (int v = 0; v < VC_NUM; v++)
            wr_en[v] = rx_flit_v_i && id_ok && (wr_vc == VC_IDX_W'(v)) &&
                       ((occ[v] != CNT_W'(VC_DEPTH)) || pop_en[v]);
        err_set = (rx_flit_v_i && !(|wr_en)) || ((|vc_pop_i) && !(|pop_en));
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
                occ[v]  <= '0;
            end else begin
                if (wr_en[v])
                    wptr[v] <= next_ptr(wptr[v]);
                if (pop_en[v])
                    rptr[v] <= next_ptr(rptr[v]);
                if (wr_en[v] && !pop_en[v])
                    occ[v] <= occ[v] + 1'b1;
                else if (!wr_en[v] && pop_en[v])
                    occ[v] <= occ[v] - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en[v]) begin
                flit_mem[v][wptr[v]]  <= rx_flit_i;
                route_mem[v][wptr[v]] <= rx_flit_look_ahead_routing_i;
            end
        end

        assign vc_head_vld_o[v]                       = (occ[v] != '0);
        assign vc_head_flit_o[v*FLIT_W +: FLIT_W]     = flit_mem[v][rptr[v]];
        assign vc_head_route_o[v*ROUTE_W +: ROUTE_W]  = route_mem[v][rptr[v]];
        assign vc_occ_o[v*CNT_W +: CNT_W]             = occ[v];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_lcrd_v_o  <= 1'b0;
            rx_lcrd_id_o <= '0;
            err_o        <= 1'b0;
        end else begin
            rx_lcrd_v_o <= |pop_en;
            if (|pop_en)
                rx_lcrd_id_o <= pop_idx;
            if (err_set)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_port_vc_buf.sv
// Scoreboard bench for input_port_vc_buf: directed scenarios then random traffic,
// checked against queue-per-VC reference model.
module tb_input_port_vc_buf;
    localparam int VC_NUM = 4, VC_DEPTH = 4, FLIT_W = 64, ROUTE_W = 3;
    localparam int VC_IDX_W = 2, CNT_W = 3;
    localparam int ENT_W = FLIT_W + ROUTE_W;

    logic                      clk = 0;
    logic                      rst_n = 0;
    logic                      rx_flit_v = 0;
    logic [FLIT_W-1:0]         rx_flit = '0;
    logic [VC_IDX_W-1:0]       rx_vc = '0;
    logic [ROUTE_W-1:0]        rx_route = '0;
    logic                      lcrd_v;
    logic [VC_IDX_W-1:0]       lcrd_id;
    logic [VC_NUM-1:0]         head_vld;
    logic [VC_NUM*FLIT_W-1:0]  head_flit;
    logic [VC_NUM*ROUTE_W-1:0] head_route;
    logic [VC_NUM-1:0]         vc_pop = '0;
    logic [VC_NUM*CNT_W-1:0]   occ;
    logic                      err;

    input_port_vc_buf #(.VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .FLIT_W(FLIT_W), .ROUTE_W(ROUTE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_flit_v_i(rx_flit_v), .rx_flit_i(rx_flit), .rx_flit_vc_id_i(rx_vc),
        .rx_flit_look_ahead_routing_i(rx_route),
        .rx_lcrd_v_o(lcrd_v), .rx_lcrd_id_o(lcrd_id),
        .vc_head_vld_o(head_vld), .vc_head_flit_o(head_flit), .vc_head_route_o(head_route),
        .vc_pop_i(vc_pop), .vc_occ_o(occ), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct { int vc; logic [ENT_W-1:0] data; } head_t;
    typedef struct { int due; int id; } cred_t;

    logic [ENT_W-1:0] mq [VC_NUM][$];
    logic             m_err;
    head_t            hq [$];
    cred_t            cq [$];
    int               cyc = 0;
    int               n_chk = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic check_state();
        chk("err", 64'(err), 64'(m_err));
        for (int v = 0; v < VC_NUM; v++) begin
            chk($sformatf("occ%0d", v), 64'(occ[v*CNT_W +: CNT_W]), 64'(mq[v].size()));
            chk($sformatf("vld%0d", v), 64'(head_vld[v]), 64'(mq[v].size() > 0));
            if (mq[v].size() > 0) begin
                chk($sformatf("head_flit%0d", v), head_flit[v*FLIT_W +: FLIT_W], mq[v][0][ENT_W-1:ROUTE_W]);
                chk($sformatf("head_route%0d", v), 64'(head_route[v*ROUTE_W +: ROUTE_W]), 64'(mq[v][0][ROUTE_W-1:0]));
            end
        end
    endtask

    // One cycle of stimulus; called #1 after a rising edge.
    task automatic step(input logic wv, input int id, input logic [FLIT_W-1:0] fl,
                        input logic [ROUTE_W-1:0] rt, input logic [VC_NUM-1:0] pop);
        int  pv;
        bit  pop_ok, wr_ok;
        head_t h;
        cred_t c;
        rx_flit_v = wv; rx_vc = VC_IDX_W'(id); rx_flit = fl; rx_route = rt; vc_pop = pop;
        pv = -1;
        for (int v = 0; v < VC_NUM; v++) if (pop[v]) pv = v;
        pop_ok = ($countones(pop) == 1) && (mq[pv].size() > 0);
        if (pop != 0 && !pop_ok) m_err = 1;
        if (pop_ok) begin
            h.vc = pv; h.data = mq[pv][0]; hq.push_back(h);
            c.due = cyc + 1; c.id = pv; cq.push_back(c);
        end
        wr_ok = 0;
        if (wv) begin
            if (mq[id].size() < VC_DEPTH || (pop_ok && pv == id)) wr_ok = 1;
            else m_err = 1;
        end
        @(posedge clk);
        if (pop_ok) void'(mq[pv].pop_front());
        if (wr_ok) mq[id].push_back({fl, rt});
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0);
    endtask

    task automatic clear_model();
        for (int v = 0; v < VC_NUM; v++) mq[v].delete();
        hq.delete();
        cq.delete();
        m_err = 0;
    endtask

    // Monitor: credits must appear exactly when due; popped heads must match issue order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cq.size() > 0 && cq[0].due == cyc) begin
                    chk("credit_v", 64'(lcrd_v), 64'd1);
                    chk("credit_id", 64'(lcrd_id), 64'(cq[0].id));
                    void'(cq.pop_front());
                end else begin
                    chk("credit_idle", 64'(lcrd_v), 64'd0);
                end
                if ($onehot(vc_pop)) begin
                    for (int v = 0; v < VC_NUM; v++) begin
                        if (vc_pop[v] && head_vld[v]) begin
                            if (hq.size() == 0) begin
                                chk("pop_unexpected", 64'(v), 64'hFFFF);
                            end else begin
                                chk("pop_vc", 64'(v), 64'(hq[0].vc));
                                chk("pop_flit", head_flit[v*FLIT_W +: FLIT_W], hq[0].data[ENT_W-1:ROUTE_W]);
                                chk("pop_route", 64'(head_route[v*ROUTE_W +: ROUTE_W]), 64'(hq[0].data[ROUTE_W-1:0]));
                                void'(hq.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int r, id;
        logic [VC_NUM-1:0] pop;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("reset_lcrd_v", 64'(lcrd_v), 64'd0);
        chk("reset_lcrd_id", 64'(lcrd_id), 64'd0);
        rst_n = 1;
        idle(2);

        // Single flit through VC2
        step(1, 2, 64'hA5, 3'd2, '0);
        idle(2);
        step(0, 0, '0, '0, 4'b0100);
        idle(2);

        // VC0 full, write+pop together across pointer wrap
        for (int i = 0; i < 4; i++) step(1, 0, 64'(16 + i), 3'(i), '0);
        for (int i = 0; i < 8; i++) step(1, 0, 64'(32 + i), 3'(i + 1), 4'b0001);
        chk("wrap_err_clear", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 4'b0001);
        idle(1);

        // Overflow on VC1, then drain plus one extra pop
        for (int i = 1; i <= 5; i++) step(1, 1, 64'(i), 3'(i), '0);
        chk("overflow_err", 64'(err), 64'd1);
        for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 4'b0010);
        idle(2);

        // Multi-hot pop
        step(1, 0, 64'h100, 3'd5, '0);
        step(1, 1, 64'h101, 3'd6, '0);
        step(0, 0, '0, '0, 4'b0011);
        idle(1);
        step(0, 0, '0, '0, 4'b0001);
        step(0, 0, '0, '0, 4'b0010);
        idle(1);

        // Reset mid-stream with VC3 holding data and a credit in flight
        rst_n = 0; clear_model(); #1; rst_n = 1;
        @(posedge clk); #1;
        step(1, 3, 64'h300, 3'd1, '0);
        step(1, 3, 64'h301, 3'd2, '0);
        step(1, 3, 64'h302, 3'd3, 4'b1000);
        rst_n = 0;
        clear_model();
        #1;
        chk("rst_lcrd_v", 64'(lcrd_v), 64'd0);
        chk("rst_vld", 64'(head_vld), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        vc_pop = '0; rx_flit_v = 0;
        @(posedge clk); #1;
        check_state();
        rst_n = 1;
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            id = $urandom_range(0, VC_NUM - 1);
            pop = '0;
            if (r < 5) pop[$urandom_range(0, VC_NUM - 1)] = 1'b1;
            else if (r == 5) pop = VC_NUM'($urandom);
            step(1'($urandom_range(0, 1)), id, {$urandom, $urandom}, 3'($urandom), pop);
        end
        idle(3);
        chk("heads_left", 64'(hq.size()), 64'd0);
        chk("credits_left", 64'(cq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
